// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB first,
// with valid/ready handshakes on operands and on the flagged result.
module add_sub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             swi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             zacc;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   ch;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] a_next;
  logic             last;
  logic             dzero;

  // One DIGIT-wide ripple slice; ch[DIGIT-1] is the carry into the top bit.
  assign ch[0] = carry;
  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      assign dsum[gi]  = a_sh[gi] ^ b_sh[gi] ^ ch[gi];
      assign ch[gi+1]  = (a_sh[gi] & b_sh[gi]) | ((a_sh[gi] ^ b_sh[gi]) & ch[gi]);
    end
  endgenerate

  // The A register doubles as the result register: sum digits fill the bits A vacates.
  generate
    if (DIGIT == WIDTH) begin : g_one
      assign a_next = dsum;
    end else begin : g_multi
      assign a_next = {dsum, a_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign last  = (cnt == CW'(N - 1));
  assign dzero = ~|dsum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      zacc      <= 1'b0;
      cnt       <= '0;
      s         <= '0;
      c         <= 1'b0;
      v         <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b ^ {WIDTH{swi}};
            carry    <= swi;
            cnt      <= '0;
            zacc     <= 1'b1;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_next;
          b_sh  <= b_sh >> DIGIT;
          carry <= ch[DIGIT];
          zacc  <= zacc & dzero;
          cnt   <= cnt + CW'(1);
          if (last) begin
            s         <= a_next;
            c         <= ch[DIGIT];
            v         <= ch[DIGIT-1] ^ ch[DIGIT];
            z         <= zacc & dzero;
            n         <= dsum[DIGIT-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
